// File: rtl/dmem_responder.sv
// Word-wide data-memory slave with valid/ready request and response channels and a
// fixed number of wait states. Optional byte write strobes under DMEM_BYTE_STROBE_EN.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  req_wstrb,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  req_strb;

`ifdef DMEM_BYTE_STROBE_EN
    assign req_strb = req_wstrb;
`else
    assign req_strb = 4'hF;
`endif

    // Storage is deliberately outside the reset domain.
    logic [31:0] mem [DEPTH];

    // Commit operands: with zero latency the commit happens on the accept edge,
    // so the live request inputs are used instead of the holding registers.
    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_strb;
    logic [29:0] c_word;
    logic [AW-1:0] c_idx;
    logic        c_err;
    logic        commit;
    logic        mem_we;

    always_comb begin
        if (LATENCY == 0 && state_q == S_IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_strb  = req_strb;
        end else begin
            c_write = write_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_strb  = strb_q;
        end
        c_word = c_addr[31:2];
        c_idx  = c_word[AW-1:0];
        c_err  = (c_addr[1:0] != 2'b00) || ({2'b00, c_word} >= DEPTH_W);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    strb_d  = req_strb;
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_write) ? 32'd0 : mem[c_idx];
        end
    end

    assign mem_we = commit && c_write && !c_err;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (c_strb[k]) mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            strb_q  <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters (DEPTH 256, LATENCY 2).
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_wstrb = 4'hF;
`endif
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    dmem_responder dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_wstrb (req_wstrb),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction with fixed-latency timing check and immediate rsp_ready.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_d, input logic exp_e);
        @(negedge clock);
        check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
        req_wstrb = s;
`endif
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        rsp_ready = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clock);
            check({tag, ".early_valid"}, {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge clock);
        check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, ".rsp_rdata"}, rsp_rdata, exp_d);
        check({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        @(negedge clock);
        check({tag, ".idle_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ".idle_rdata"}, rsp_rdata, 32'd0);
        check({tag, ".idle_err"}, {31'd0, rsp_err}, 32'd0);
        check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset held with random inputs
        repeat (3) begin
            @(posedge clock);
            #1;
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            rsp_ready = 1'($urandom);
        end
        @(negedge clock);
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clock);
        check("rel.req_ready", {31'd0, req_ready}, 32'd1);
        check("rel.busy", {31'd0, busy}, 32'd0);

        // Write then read
        txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        txn("ld10", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0);
        txn("st24", 1'b1, 32'h24, 32'h5A5A5A5A, 4'hF, 32'd0, 1'b0);

        // Backpressure with an ignored request in flight
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (LAT + 1) @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h24;
        req_wdata = 32'h00000BAD;
        for (int k = 0; k < 5; k++) begin
            check("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp.rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp.req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clock);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        @(negedge clock);
        check("bp.ret_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp.ret_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        check("bp.no_extra", {31'd0, busy}, 32'd0);
        txn("ld24", 1'b0, 32'h24, 32'd0, 4'hF, 32'h5A5A5A5A, 1'b0);

        // Errors and top-of-range boundary
        txn("st13", 1'b1, 32'h13, 32'h12345678, 4'hF, 32'd0, 1'b1);
        txn("ld10b", 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0);
        txn("ld400", 1'b0, 32'h400, 32'd0, 4'hF, 32'd0, 1'b1);
        txn("st3fc", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
        txn("ld3fc", 1'b0, 32'h3FC, 32'd0, 4'hF, 32'hCAFEF00D, 1'b0);
        txn("ld3fe", 1'b0, 32'h3FE, 32'd0, 4'hF, 32'd0, 1'b1);

        // Reset during WAIT discards the store
        txn("st20a", 1'b1, 32'h20, 32'h11111111, 4'hF, 32'd0, 1'b0);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h22222222;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("mid.busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid.rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid.rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        rst = 1'b1;
        txn("ld20", 1'b0, 32'h20, 32'd0, 4'hF, 32'h11111111, 1'b0);

`ifdef DMEM_BYTE_STROBE_EN
        txn("sb.init", 1'b1, 32'h30, 32'hAABBCCDD, 4'hF, 32'd0, 1'b0);
        txn("sb.0101", 1'b1, 32'h30, 32'h11223344, 4'b0101, 32'd0, 1'b0);
        txn("sb.ld1", 1'b0, 32'h30, 32'd0, 4'b0000, 32'hAA22CC44, 1'b0);
        txn("sb.0000", 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0);
        txn("sb.ld2", 1'b0, 32'h30, 32'd0, 4'hF, 32'hAA22CC44, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
